// File: rtl/varint_encoder_pkg.sv
// Shared constants and types for the protobuf varint encoder.
package protobuf_pkg;

    // Field index width matching the upstream index bus.
    localparam int INDEX_W_DEFAULT = 10;

    // Protobuf wire type for varint-encoded fields.
    localparam logic [2:0] WIRE_VARINT = 3'd0;

    // A 64-bit value needs at most ten 7-bit groups.
    localparam int VARINT_MAX_BYTES = 10;

    // Width of the internal value register and of the shift register.
    localparam int VALUE_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_HI,
        KEY,
        VAL
    } state_t;

endpackage

// File: rtl/varint_encoder_if.sv
// Encoded byte stream leaving the varint encoder towards the output packer.
interface varint_encoder_if
    import protobuf_pkg::*;
#(
    parameter int INDEX_W = INDEX_W_DEFAULT
);

    logic [7:0]         out_byte;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic [INDEX_W-1:0] out_index;

    // Encoder side drives the bytes.
    modport master (
        output out_byte,
        output out_valid,
        output out_last,
        output out_index,
        input  out_ready
    );

    // Consumer side accepts the bytes.
    modport slave (
        input  out_byte,
        input  out_valid,
        input  out_last,
        input  out_index,
        output out_ready
    );

endinterface

// File: rtl/varint_encoder_byte_gen.sv
// Loadable 64-bit shift register that presents one varint byte at a time.
module varint_byte_gen
    import protobuf_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [VALUE_W-1:0] load_value,
    input  logic               shift,
    output logic [7:0]         cur_byte,
    output logic               cont,
    output logic               last
);

    logic [VALUE_W-1:0] shreg;

    // Load a fresh value, or drop the 7-bit group just accepted downstream.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= load_value;
        end else if (shift) begin
            shreg <= shreg >> 7;
        end
    end

    // Continuation is set while any higher group remains non-zero.
    always_comb begin
        cont     = |shreg[VALUE_W-1:7];
        last     = ~cont;
        cur_byte = {cont, shreg[6:0]};
    end

endmodule

// File: rtl/varint_encoder.sv
// Pops varint records from the input FIFOs and emits their protobuf encoding
// (optional key varint followed by the value varint) as a byte stream.
module varint_encoder
    import protobuf_pkg::*;
#(
    parameter int INDEX_W  = INDEX_W_DEFAULT,
    parameter bit EMIT_KEY = 1'b1
) (
    input  logic               clk,
    input  logic               reset,

    input  logic [31:0]        varint_in_fifo_data,
    input  logic               varint_in_fifo_empty,
    output logic               varint_in_fifo_pop,

    input  logic [INDEX_W-1:0] varint_in_index_data,
    input  logic               varint_in_index_empty,
    output logic               varint_in_index_pop,

    input  logic               varint_in_size_data,
    output logic               varint_in_size_pop,

    varint_encoder_if.master   stream,

    output logic               busy
);

    localparam int     KEY_W      = INDEX_W + 3;
    localparam state_t AFTER_LOAD = EMIT_KEY ? KEY : VAL;

    state_t             state, state_d;
    logic [VALUE_W-1:0] value_q;
    logic [KEY_W-1:0]   key_q;
    logic [INDEX_W-1:0] field_q;
    logic [3:0]         byte_cnt;

    logic               pop_index, pop_data;
    logic               latch_lo, latch_hi;
    logic               gen_load, gen_shift;
    logic [VALUE_W-1:0] gen_load_value;
    logic [7:0]         gen_byte;
    logic               gen_cont, gen_last;
    logic               out_valid;

    varint_byte_gen u_byte_gen (
        .clk        (clk),
        .reset      (reset),
        .load       (gen_load),
        .load_value (gen_load_value),
        .shift      (gen_shift),
        .cur_byte   (gen_byte),
        .cont       (gen_cont),
        .last       (gen_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state, FIFO pops and shift-register control.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        state_d        = state;
        pop_index      = 1'b0;
        pop_data       = 1'b0;
        latch_lo       = 1'b0;
        latch_hi       = 1'b0;
        gen_load       = 1'b0;
        gen_load_value = '0;
        gen_shift      = 1'b0;
        out_valid      = 1'b0;

        unique case (state)
            IDLE: begin
                if (!reset && !varint_in_index_empty && !varint_in_fifo_empty) begin
                    pop_index = 1'b1;
                    pop_data  = 1'b1;
                    latch_lo  = 1'b1;
                    if (varint_in_size_data) begin
                        state_d = LOAD_HI;
                    end else begin
                        gen_load       = 1'b1;
                        gen_load_value = EMIT_KEY
                            ? VALUE_W'({varint_in_index_data, WIRE_VARINT})
                            : VALUE_W'(varint_in_fifo_data);
                        state_d        = AFTER_LOAD;
                    end
                end
            end

            LOAD_HI: begin
                if (!reset && !varint_in_fifo_empty) begin
                    pop_data       = 1'b1;
                    latch_hi       = 1'b1;
                    gen_load       = 1'b1;
                    gen_load_value = EMIT_KEY
                        ? VALUE_W'(key_q)
                        : {varint_in_fifo_data, value_q[31:0]};
                    state_d        = AFTER_LOAD;
                end
            end

            KEY: begin
                out_valid = 1'b1;
                if (stream.out_ready) begin
                    if (gen_cont) begin
                        gen_shift = 1'b1;
                    end else begin
                        gen_load       = 1'b1;
                        gen_load_value = value_q;
                        state_d        = VAL;
                    end
                end
            end

            VAL: begin
                out_valid = 1'b1;
                if (stream.out_ready) begin
                    gen_shift = 1'b1;
                    if (!gen_cont) begin
                        state_d = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Record registers: value halves, key and field index captured at the pops.
    always_ff @(posedge clk) begin
        // NOTE: these data registers are cleared on reset so a discarded record leaves no stale index on the bus.
        if (reset) begin
            value_q <= '0;
            key_q   <= '0;
            field_q <= '0;
        end else begin
            if (latch_lo) begin
                value_q <= VALUE_W'(varint_in_fifo_data);
                key_q   <= {varint_in_index_data, WIRE_VARINT};
                field_q <= varint_in_index_data;
            end
            if (latch_hi) begin
                value_q[63:32] <= varint_in_fifo_data;
            end
        end
    end

    // Count value bytes accepted, saturating at the 64-bit maximum.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt <= '0;
        end else if (state_d == VAL && state != VAL) begin
            byte_cnt <= '0;
        end else if (state == VAL && gen_shift && byte_cnt != 4'(VARINT_MAX_BYTES)) begin
            byte_cnt <= byte_cnt + 4'd1;
        end
    end

    // Guard: a value varint never needs an eleventh byte.
    always_ff @(posedge clk) begin
        if (!reset && state == VAL && gen_shift) begin
            assert (byte_cnt < 4'(VARINT_MAX_BYTES));
        end
    end

    // Output drive; the byte bus is forced to zero outside KEY/VAL.
    always_comb begin
        stream.out_valid      = out_valid;
        stream.out_byte       = out_valid ? gen_byte : 8'h00;
        stream.out_last       = (state == VAL) && gen_last;
        stream.out_index      = field_q;
        busy                  = (state != IDLE);
        varint_in_index_pop   = pop_index;
        varint_in_size_pop    = pop_index;
        varint_in_fifo_pop    = pop_data;
    end

endmodule

// File: tb/tb_varint_encoder.sv
// Directed testbench for varint_encoder with FIFO models and a byte monitor.
module tb_varint_encoder;

    logic        clk;
    logic        reset;
    logic [31:0] fifo_data;
    logic        fifo_empty;
    logic        fifo_pop;
    logic [9:0]  index_data;
    logic        index_empty;
    logic        index_pop;
    logic        size_data;
    logic        size_pop;
    logic        busy;

    varint_encoder_if #(.INDEX_W(10)) stream ();

    varint_encoder #(.INDEX_W(10), .EMIT_KEY(1'b1)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .varint_in_fifo_data   (fifo_data),
        .varint_in_fifo_empty  (fifo_empty),
        .varint_in_fifo_pop    (fifo_pop),
        .varint_in_index_data  (index_data),
        .varint_in_index_empty (index_empty),
        .varint_in_index_pop   (index_pop),
        .varint_in_size_data   (size_data),
        .varint_in_size_pop    (size_pop),
        .stream                (stream),
        .busy                  (busy)
    );

    typedef struct {
        logic [7:0] b;
        logic       l;
        logic [9:0] idx;
        int         cyc;
    } rx_t;

    logic [31:0] data_q[$];
    logic [9:0]  index_q[$];
    logic        size_q[$];
    rx_t         rx[$];
    logic [7:0]  exp_b[$];
    logic        exp_l[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int data_pops = 0;
    int index_pops = 0;
    int pop_cyc = 0;
    int pop_mismatch = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        fifo_data   = (data_q.size() != 0) ? data_q[0] : 32'h0;
        fifo_empty  = (data_q.size() == 0);
        index_data  = (index_q.size() != 0) ? index_q[0] : 10'h0;
        index_empty = (index_q.size() == 0);
        size_data   = (size_q.size() != 0) ? size_q[0] : 1'b0;
    endtask

    task automatic push_rec(input logic [31:0] d, input logic [9:0] idx, input logic is64);
        data_q.push_back(d);
        index_q.push_back(idx);
        size_q.push_back(is64);
        refresh();
    endtask

    task automatic push_data(input logic [31:0] d);
        data_q.push_back(d);
        refresh();
    endtask

    task automatic expect_byte(input logic [7:0] b, input logic l);
        exp_b.push_back(b);
        exp_l.push_back(l);
    endtask

    task automatic wait_rx(input string tag, input int n);
        int budget = 0;
        while (rx.size() < n && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        check({tag, "_byte_count"}, 64'(rx.size()), 64'(n));
    endtask

    task automatic compare_stream(input string tag, input logic [9:0] idx);
        for (int i = 0; i < exp_b.size(); i++) begin
            if (i < rx.size()) begin
                check($sformatf("%s_byte%0d", tag, i), 64'(rx[i].b), 64'(exp_b[i]));
                check($sformatf("%s_last%0d", tag, i), 64'(rx[i].l), 64'(exp_l[i]));
                check($sformatf("%s_index%0d", tag, i), 64'(rx[i].idx), 64'(idx));
            end
        end
    endtask

    task automatic clear_run();
        rx.delete();
        exp_b.delete();
        exp_l.delete();
        data_pops  = 0;
        index_pops = 0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 64'(stream.out_valid), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_byte"}, 64'(stream.out_byte), 64'(0));
        check({tag, "_last"}, 64'(stream.out_last), 64'(0));
        check({tag, "_index"}, 64'(stream.out_index), 64'(0));
        check({tag, "_pops"}, 64'({fifo_pop, index_pop, size_pop}), 64'(0));
    endtask

    // Monitor: sample just before the rising edge, then retire popped FIFO entries.
    always @(negedge clk) begin
        logic p_data, p_idx;
        #4;
        cyc++;
        p_data = fifo_pop;
        p_idx  = index_pop;
        if (index_pop !== size_pop) pop_mismatch++;
        if (p_idx) pop_cyc = cyc;
        if (stream.out_valid && stream.out_ready) begin
            rx.push_back('{b: stream.out_byte, l: stream.out_last, idx: stream.out_index, cyc: cyc});
        end
        @(posedge clk);
        #1;
        if (p_data) begin
            data_pops++;
            if (data_q.size() != 0) void'(data_q.pop_front());
        end
        if (p_idx) begin
            index_pops++;
            if (index_q.size() != 0) void'(index_q.pop_front());
            if (size_q.size() != 0) void'(size_q.pop_front());
        end
        refresh();
    end

    initial begin
        reset = 1'b1;
        stream.out_ready = 1'b1;
        refresh();
        repeat (3) @(negedge clk);
        check_idle("reset");
        reset = 1'b0;
        @(negedge clk);
        clear_run();

        // 32-bit record, index 1.
        push_rec(32'h1234_5678, 10'd1, 1'b0);
        wait_rx("t1", 6);
        expect_byte(8'h08, 1'b0);
        expect_byte(8'hF8, 1'b0);
        expect_byte(8'hAC, 1'b0);
        expect_byte(8'hD1, 1'b0);
        expect_byte(8'h91, 1'b0);
        expect_byte(8'h01, 1'b1);
        compare_stream("t1", 10'd1);
        if (rx.size() != 0) check("t1_latency", 64'(rx[0].cyc - pop_cyc), 64'(1));
        check("t1_data_pops", 64'(data_pops), 64'(1));
        check("t1_index_pops", 64'(index_pops), 64'(1));
        repeat (2) @(negedge clk);
        clear_run();

        // Two-byte key, two-byte value.
        push_rec(32'h0000_012C, 10'd150, 1'b0);
        wait_rx("t2", 4);
        expect_byte(8'hB0, 1'b0);
        expect_byte(8'h09, 1'b0);
        expect_byte(8'hAC, 1'b0);
        expect_byte(8'h02, 1'b1);
        compare_stream("t2", 10'd150);
        repeat (2) @(negedge clk);
        clear_run();

        // 64-bit all-ones, high word arrives late.
        push_rec(32'hFFFF_FFFF, 10'd1023, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check("t3_wait_valid", 64'(stream.out_valid), 64'(0));
            check("t3_wait_busy", 64'(busy), 64'(1));
        end
        push_data(32'hFFFF_FFFF);
        wait_rx("t3", 12);
        expect_byte(8'hF8, 1'b0);
        expect_byte(8'h3F, 1'b0);
        for (int i = 0; i < 9; i++) expect_byte(8'hFF, 1'b0);
        expect_byte(8'h01, 1'b1);
        compare_stream("t3", 10'd1023);
        check("t3_data_pops", 64'(data_pops), 64'(2));
        check("t3_index_pops", 64'(index_pops), 64'(1));
        repeat (2) @(negedge clk);
        clear_run();

        // Value zero with a stalled key byte.
        stream.out_ready = 1'b0;
        push_rec(32'h0, 10'd2, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("t4_stall_valid", 64'(stream.out_valid), 64'(1));
            check("t4_stall_byte", 64'(stream.out_byte), 64'(8'h10));
            check("t4_stall_last", 64'(stream.out_last), 64'(0));
        end
        stream.out_ready = 1'b1;
        wait_rx("t4", 2);
        expect_byte(8'h10, 1'b0);
        expect_byte(8'h00, 1'b1);
        compare_stream("t4", 10'd2);
        repeat (2) @(negedge clk);
        clear_run();

        // Back-to-back records with one idle bubble between them.
        push_rec(32'h7F, 10'd1, 1'b0);
        push_rec(32'h80, 10'd1, 1'b0);
        wait_rx("t5", 5);
        expect_byte(8'h08, 1'b0);
        expect_byte(8'h7F, 1'b1);
        expect_byte(8'h08, 1'b0);
        expect_byte(8'h80, 1'b0);
        expect_byte(8'h01, 1'b1);
        compare_stream("t5", 10'd1);
        if (rx.size() >= 3) check("t5_bubble", 64'(rx[2].cyc - rx[1].cyc), 64'(2));
        repeat (2) @(negedge clk);
        clear_run();

        // Reset in the middle of the value bytes, then a clean record.
        push_rec(32'h1234_5678, 10'd5, 1'b0);
        wait_rx("t6_pre", 3);
        reset = 1'b1;
        stream.out_ready = 1'b0;
        @(negedge clk);
        check_idle("t6_reset");
        reset = 1'b0;
        stream.out_ready = 1'b1;
        clear_run();
        push_rec(32'h0000_012C, 10'd150, 1'b0);
        wait_rx("t6", 4);
        expect_byte(8'hB0, 1'b0);
        expect_byte(8'h09, 1'b0);
        expect_byte(8'hAC, 1'b0);
        expect_byte(8'h02, 1'b1);
        compare_stream("t6", 10'd150);
        repeat (2) @(negedge clk);

        check("size_pop_tracks_index_pop", 64'(pop_mismatch), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
